fifo_flags: RTL and testbench
=============================

# fifo_flags

Parametrised synchronous FIFO; successor to the basic `fifo` block. Adds:
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- sticky overflow and underflow error flags;
- a synchronous flush;
- a selectable first-word-fall-through (FWFT) read mode.

It sits between a producer and a consumer in the same clock domain and drops in wherever `fifo` is used today.

## Interface
- `DATA_WIDTH`, 8, data bits per entry (≥1)
- `DEPTH`, 16, number of entries (≥2; not required to be a power of two)
- `AF_LEVEL`, DEPTH-2, `almost_full` asserts when count ≥ AF_LEVEL (1..DEPTH)
- `AE_LEVEL`, 2, `almost_empty` asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- `FWFT`, 0, read mode:
  - 0 = standard (registered read, 1-cycle latency)
  - 1 = first-word-fall-through
- `CW` (local), $clog2(DEPTH+1), count width

Ports:
- `clk` in 1 — single clock; all state updates on posedge
- `rst_` in 1 — reset:
  - asynchronous and active-high; assert = 1
  - the `rst_` name is kept for codebase consistency; the polarity is high
- `flush` in 1 — synchronous clear of contents
- `clr_err` in 1 — synchronous clear of `overflow`/`underflow`
- `wr_en` in 1 — write request
- `din` in DATA_WIDTH — write data
- `rd_en` in 1 — read request (pop)
- `dout` out DATA_WIDTH — read data
- `full` out 1 — count == DEPTH
- `empty` out 1 — count == 0
- `almost_full` out 1 — count ≥ AF_LEVEL
- `almost_empty` out 1 — count ≤ AE_LEVEL
- `count` out CW — current occupancy
- `overflow` out 1 — sticky: a write was attempted while full and not accepted
- `underflow` out 1 — sticky: a read was attempted while empty

## Operation
- **Storage:** DEPTH×DATA_WIDTH register array.
- **Pointers:** `wr_ptr` and `rd_ptr` each wrap from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- **Count register:** `count` updates as follows:
  - +1 on an accepted write only
  - −1 on an accepted read only
  - unchanged when both are accepted
- **Write acceptance:** `wr_acc = wr_en & (!full | rd_acc)`.
  - A write while full is accepted only together with an accepted read; count stays DEPTH.
- **Read acceptance:** `rd_acc = rd_en & !empty`.
  - A simultaneous read and write while empty accepts the write and rejects the read.
  - `underflow` sets in that case.
- **Error flags:**
  - `wr_en & !wr_acc` sets `overflow`.
  - `rd_en & empty` sets `underflow`.
  - Both flags hold until `clr_err`. If clear and set occur in the same cycle, set wins.
- **Flush:**
  - Zeroes the pointers and `count` at the next posedge.
  - Flush beats `wr_en`/`rd_en` in the same cycle; those requests are ignored and raise no errors.
  - Flush does not clear the error flags or the `dout` register.
- **Flags:** all are decoded from registered `count`, so every flag changes only after a posedge.
- **`dout` when FWFT=0:**
  - Registered; loads `mem[rd_ptr]` on `rd_acc`.
  - Otherwise holds its last value, including when empty.
- **`dout` when FWFT=1:**
  - Equals `mem[rd_ptr]` whenever `!empty`; `rd_en` pops the current word.
  - When empty, `dout` is don't-care; the bench must not check it.

## Timing
- **Reset values** (asynchronous; apply immediately on `rst_`=1):
  - `dout`=0, `count`=0
  - `empty`=1, `full`=0
  - `almost_empty`=1, `almost_full`=0
  - `overflow`=0, `underflow`=0
  - pointers 0
- **Reset mid-operation:** contents are discarded and all state returns to the reset values. Memory contents are not cleared, but are unreachable.
- **Write latency:** a write accepted at posedge N makes `count`, `empty` and the other flags reflect it after N.
  - FWFT=1: the word is visible on `dout` after N, in the same cycle `empty` falls.
- **Read latency:**
  - FWFT=0: data for a read accepted at posedge N is valid on `dout` after N, i.e. sampled at the following negedge.
  - FWFT=1: data is valid before the pop; after N, `dout` shows the next word.
- **Throughput:** one write and one read per cycle sustained; no bubbles at pointer wrap.
- **Fill time:** `full` asserts after exactly DEPTH accepted writes from empty. `empty` asserts after the matching number of reads.

## Test plan
- **Reset:** with DEPTH=16, write 16 values 0..15, then read 16 times (FWFT=0).
  - Reads return 0..15 in order.
  - `full`=1 after the 16th write; `empty`=1 after the 16th read.
  - `count` traces 0→16→0.
- **Thresholds** (AF_LEVEL=14, AE_LEVEL=2):
  - `almost_full` rises on the 14th write and falls when count drops to 13.
  - `almost_empty` =1 at count ≤2 and =0 at count 3.
- **Overflow/underflow:**
  - A 17th write while full does not change contents and sets `overflow`; reading then returns 0..15 unchanged.
  - A read on empty sets `underflow`.
  - `clr_err` clears both flags one cycle later.
- **Simultaneous read+write:**
  - Empty: count becomes 1 and `underflow` sets.
  - count=5: count stays 5 and data order is preserved.
  - Full: count stays 16; the new word emerges last.
- **Wrap and flush:**
  - Run 40 interleaved write/read pairs across the pointer wrap with DEPTH=12; data is in order.
  - `flush` at count=7 concurrent with `wr_en`: count=0, `empty`=1, error flags unchanged.
- **FWFT=1:**
  - Write 0xA5 to empty: `dout`=0xA5 in the cycle after the write, with `empty`=0.
  - `rd_en` pops it; an async `rst_` pulse mid-stream returns all outputs to their reset values immediately.

Source files
------------

// File: rtl/fifo_flags.sv
// Synchronous FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, synchronous flush and optional FWFT read.
module fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // Flush masks both requests so they neither move state nor raise errors.
  assign rd_acc = rd_en & ~empty & ~flush;
  assign wr_acc = wr_en & (~full | rd_acc) & ~flush;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Set wins over clear when both happen in the same cycle.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (~flush & wr_en & ~wr_acc) overflow  <= 1'b1;
      if (~flush & rd_en & empty)   underflow <= 1'b1;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge rst_) begin
        if (rst_)        dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr];
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: queue model checked every negedge on a standard-mode
// DEPTH=16 instance and an FWFT DEPTH=12 instance, plus directed literal checks.
module tb_fifo_flags;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en [2];
  logic       rd_en [2];
  logic       flush [2];
  logic       clr_err [2];
  logic [7:0] din [2];
  logic [7:0] dout [2];
  logic       full [2];
  logic       empty [2];
  logic       afull [2];
  logic       aempty [2];
  logic       ovf [2];
  logic       unf [2];
  logic [4:0] cnt0;
  logic [3:0] cnt1;
  logic [4:0] cnt_o [2];

  int total = 0;
  int bad   = 0;

  int dep [2] = '{16, 12};
  int afl [2] = '{14, 10};
  int ael [2] = '{2, 2};

  bit [7:0] mq [2][$];
  bit       m_ovf [2];
  bit       m_unf [2];
  bit [7:0] exp_dout [2];

  always #5 clk = ~clk;

  assign cnt_o[0] = cnt0;
  assign cnt_o[1] = {1'b0, cnt1};

  fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u0 (
    .clk(clk), .rst_(rst), .flush(flush[0]), .clr_err(clr_err[0]),
    .wr_en(wr_en[0]), .din(din[0]), .rd_en(rd_en[0]), .dout(dout[0]),
    .full(full[0]), .empty(empty[0]), .almost_full(afull[0]), .almost_empty(aempty[0]),
    .count(cnt0), .overflow(ovf[0]), .underflow(unf[0]));

  fifo_flags #(.DATA_WIDTH(8), .DEPTH(12), .AF_LEVEL(10), .AE_LEVEL(2), .FWFT(1'b1)) u1 (
    .clk(clk), .rst_(rst), .flush(flush[1]), .clr_err(clr_err[1]),
    .wr_en(wr_en[1]), .din(din[1]), .rd_en(rd_en[1]), .dout(dout[1]),
    .full(full[1]), .empty(empty[1]), .almost_full(afull[1]), .almost_empty(aempty[1]),
    .count(cnt1), .overflow(ovf[1]), .underflow(unf[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: a queue of accepted words plus the two sticky flags.
  always @(posedge clk or posedge rst) begin : model
    int n;
    bit rd_ok, wr_ok;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
        exp_dout[i] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clr_err[i]) begin
          m_ovf[i] = 1'b0;
          m_unf[i] = 1'b0;
        end
        if (flush[i]) begin
          mq[i].delete();
        end else begin
          n = mq[i].size();
          rd_ok = rd_en[i] && (n > 0);
          wr_ok = wr_en[i] && ((n < dep[i]) || rd_ok);
          if (wr_en[i] && !wr_ok) m_ovf[i] = 1'b1;
          if (rd_en[i] && (n == 0)) m_unf[i] = 1'b1;
          if (rd_ok) exp_dout[i] = mq[i].pop_front();
          if (wr_ok) mq[i].push_back(din[i]);
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int n;
    for (int i = 0; i < 2; i++) begin
      n = mq[i].size();
      chk($sformatf("u%0d count", i), cnt_o[i], n);
      chk($sformatf("u%0d empty", i), empty[i], n == 0);
      chk($sformatf("u%0d full", i), full[i], n == dep[i]);
      chk($sformatf("u%0d almost_full", i), afull[i], n >= afl[i]);
      chk($sformatf("u%0d almost_empty", i), aempty[i], n <= ael[i]);
      chk($sformatf("u%0d overflow", i), ovf[i], m_ovf[i]);
      chk($sformatf("u%0d underflow", i), unf[i], m_unf[i]);
      if (i == 0) chk("u0 dout", dout[0], exp_dout[0]);
      else if (n > 0) chk("u1 dout", dout[1], mq[1][0]);
    end
  end

  task automatic idle_inputs();
    for (int j = 0; j < 2; j++) begin
      wr_en[j] = 1'b0; rd_en[j] = 1'b0; flush[j] = 1'b0; clr_err[j] = 1'b0; din[j] = 8'h00;
    end
  endtask

  task automatic drive(input int i, input bit we, input logic [7:0] d, input bit re,
                       input bit fl, input bit ce);
    idle_inputs();
    wr_en[i] = we; din[i] = d; rd_en[i] = re; flush[i] = fl; clr_err[i] = ce;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #3;
    chk("reset count", cnt0, 0);
    chk("reset empty", empty[0], 1);
    chk("reset full", full[0], 0);
    chk("reset almost_empty", aempty[0], 1);
    chk("reset almost_full", afull[0], 0);
    chk("reset overflow", ovf[0], 0);
    chk("reset underflow", unf[0], 0);
    chk("reset dout", dout[0], 0);
    chk("reset u1 dout", dout[1], 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Fill 0..15, thresholds on the way up
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, 8'(k), 0, 0, 0);
      chk("fill count", cnt0, k + 1);
      if (k == 12) chk("af at 13", afull[0], 0);
      if (k == 13) chk("af at 14", afull[0], 1);
      if (k == 1)  chk("ae at 2", aempty[0], 1);
      if (k == 2)  chk("ae at 3", aempty[0], 0);
    end
    chk("full after 16", full[0], 1);
    drive(0, 1, 8'd99, 0, 0, 0);
    chk("overflow on 17th", ovf[0], 1);
    chk("count held 16", cnt0, 16);
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 8'h00, 1, 0, 0);
      chk("drain data", dout[0], k);
      if (k == 1) chk("af at 14 down", afull[0], 1);
      if (k == 2) chk("af at 13 down", afull[0], 0);
    end
    chk("empty after 16", empty[0], 1);
    chk("count back 0", cnt0, 0);
    drive(0, 0, 8'h00, 1, 0, 0);
    chk("underflow on empty", unf[0], 1);
    drive(0, 0, 8'h00, 0, 0, 1);
    chk("clr overflow", ovf[0], 0);
    chk("clr underflow", unf[0], 0);

    // Simultaneous read+write: empty, count=5, full
    drive(0, 1, 8'h33, 1, 0, 0);
    chk("rw empty count", cnt0, 1);
    chk("rw empty underflow", unf[0], 1);
    drive(0, 0, 8'h00, 0, 0, 1);
    drive(0, 0, 8'h00, 1, 0, 0);
    chk("rw empty data", dout[0], 8'h33);
    for (int k = 0; k < 5; k++) drive(0, 1, 8'(8'h40 + k), 0, 0, 0);
    drive(0, 1, 8'h45, 1, 0, 0);
    chk("rw5 count", cnt0, 5);
    chk("rw5 dout", dout[0], 8'h40);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 8'h00, 1, 0, 0);
      chk("rw5 order", dout[0], 8'h41 + k);
    end
    for (int k = 0; k < 16; k++) drive(0, 1, 8'(8'h50 + k), 0, 0, 0);
    drive(0, 1, 8'h7f, 1, 0, 0);
    chk("rw full count", cnt0, 16);
    chk("rw full dout", dout[0], 8'h50);
    chk("rw full no ovf", ovf[0], 0);
    for (int k = 0; k < 16; k++) drive(0, 0, 8'h00, 1, 0, 0);
    chk("rw full last word", dout[0], 8'h7f);

    // Flush with concurrent write; flags preserved
    drive(0, 0, 8'h00, 1, 0, 0);
    for (int k = 0; k < 7; k++) drive(0, 1, 8'(8'h60 + k), 0, 0, 0);
    chk("pre-flush count", cnt0, 7);
    drive(0, 1, 8'hee, 0, 1, 0);
    chk("flush count", cnt0, 0);
    chk("flush empty", empty[0], 1);
    chk("flush keeps underflow", unf[0], 1);
    chk("flush no overflow", ovf[0], 0);
    chk("flush keeps dout", dout[0], 8'h7f);
    drive(0, 0, 8'h00, 0, 0, 1);

    // FWFT instance
    drive(1, 1, 8'ha5, 0, 0, 0);
    chk("fwft dout a5", dout[1], 8'ha5);
    chk("fwft not empty", empty[1], 0);
    drive(1, 0, 8'h00, 1, 0, 0);
    chk("fwft popped empty", empty[1], 1);
    for (int k = 0; k < 3; k++) drive(1, 1, 8'(k), 0, 0, 0);
    for (int k = 0; k < 40; k++) drive(1, 1, 8'(k + 3), 1, 0, 0);
    chk("wrap head", dout[1], 40);
    chk("wrap count", cnt1, 3);
    drive(1, 1, 8'hc3, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid rst count", cnt1, 0);
    chk("mid rst empty", empty[1], 1);
    chk("mid rst full", full[1], 0);
    chk("mid rst ae", aempty[1], 1);
    chk("mid rst af", afull[1], 0);
    chk("mid rst ovf", ovf[1], 0);
    chk("mid rst unf", unf[1], 0);
    chk("mid rst dout", dout[1], 0);
    chk("mid rst u0 dout", dout[0], 0);
    @(negedge clk);
    #2 rst = 1'b0;
    drive(1, 1, 8'h5a, 0, 0, 0);
    chk("post rst fwft", dout[1], 8'h5a);
    drive(1, 0, 8'h00, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
